// File: rtl/alu_seq_ctrl_pkg.sv
// Shared constants for the ALU sequencing controller: opcodes, FSM encoding,
// status bit positions and the legal-opcode decode.
package alu_seq_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;
  localparam int FLAG_W   = 5;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;
  localparam logic [7:0] OP_NOT = 8'h08;
  localparam logic [7:0] OP_SL  = 8'h09;
  localparam logic [7:0] OP_SR  = 8'h0A;

  // Status register bit positions, packed as {Z,N,C,V,H}.
  localparam int STAT_Z = 4;
  localparam int STAT_N = 3;
  localparam int STAT_C = 2;
  localparam int STAT_V = 1;
  localparam int STAT_H = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op == OP_LD) || ((op >= OP_ADD) && (op <= OP_SR));
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x32 register file: two combinational operand reads, one debug read,
// one synchronous write, cleared asynchronously by rst.
module alu_regfile
  import alu_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // NOTE: this array is reset on purpose (reset must zero every register), so
  // it becomes flops rather than RAM; unreset memories would not need the loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Reads see the pre-write value during the write cycle; no bypass.
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one instruction at a time through an external ALU:
// IDLE -> ISSUE -> WB (or IDLE -> ERR for illegal opcodes), then back to IDLE.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_ra,
  input  logic [REG_AW-1:0] instr_rb,
  input  logic              instr_imm_en,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              alu_h,
  output logic [FLAG_W-1:0] status,
  output logic              done,
  output logic              err,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t              state, next_state;
  logic                accept;
  logic [7:0]          op_q;
  logic [REG_AW-1:0]   rd_q;
  logic [DATA_W-1:0]   res_q;
  logic [FLAG_W-1:0]   flags_q;
  logic [DATA_W-1:0]   ra_data, rb_data;
  logic                wr_en;

  assign accept = instr_valid && (state == ST_IDLE);
  assign wr_en  = (state == ST_WB);

  alu_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (instr_ra),
    .rd_data_a (ra_data),
    .rd_addr_b (instr_rb),
    .rd_data_b (rb_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_en     (wr_en),
    .wr_addr   (rd_q),
    .wr_data   (res_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    alu_op      = OP_NOP;
    unique case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) next_state = is_legal_op(instr_op) ? ST_ISSUE : ST_ERR;
      end
      ST_ISSUE: begin
        alu_op     = op_q;
        next_state = ST_WB;
      end
      ST_WB: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      ST_ERR: begin
        err        = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operands latch only on accept; the ALU result is captured on the edge
  // ending ISSUE, after the ALU evaluated on the intervening falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      status  <= '0;
    end else begin
      if (accept) begin
        alu_a <= ra_data;
        alu_b <= instr_imm_en ? instr_imm : rb_data;
        op_q  <= instr_op;
        rd_q  <= instr_rd;
      end
      if (state == ST_ISSUE) begin
        res_q   <= alu_out;
        flags_q <= {alu_z, alu_n, alu_c, alu_v, alu_h};
      end
      if ((state == ST_WB) && (op_q != OP_LD)) status <= flags_q;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench: behavioural ALU stub plus an architectural model
// (register array + status) updated per completed instruction.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready;
  logic [7:0]  instr_op;
  logic [2:0]  instr_rd, instr_ra, instr_rb;
  logic        instr_imm_en;
  logic [31:0] instr_imm;
  logic [31:0] alu_a, alu_b;
  logic [7:0]  alu_op;
  logic [31:0] alu_out = '0;
  logic        alu_z = 0, alu_n = 0, alu_c = 0, alu_v = 0, alu_h = 0;
  logic [4:0]  status;
  logic        done, err;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [8];
  logic [4:0]  mstatus;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v), .alu_h(alu_h),
    .status(status), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Returns {Z,N,C,V,H,result}. C is carry-out for ADD and borrow for SUB.
  function automatic logic [36:0] alu_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic c, v, h;
    r = '0; c = 0; v = 0; h = 0;
    case (op)
      8'h01: r = b;
      8'h03: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0]; c = wide[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
        h = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
      end
      8'h04: begin
        r = a - b; c = a < b;
        v = (a[31] != b[31]) && (r[31] != a[31]);
        h = a[3:0] < b[3:0];
      end
      8'h05: r = a & b;
      8'h06: r = a | b;
      8'h07: r = a ^ b;
      8'h08: r = ~a;
      8'h09: r = a << b[4:0];
      8'h0A: r = a >> b[4:0];
      default: r = '0;
    endcase
    return {(r == 32'd0), r[31], c, v, h, r};
  endfunction

  function automatic logic legal_op(input logic [7:0] op);
    return (op == 8'h01) || (op >= 8'h03 && op <= 8'h0A);
  endfunction

  // External ALU stub: evaluates on the falling edge, holds while op is 00.
  always @(negedge clk)
    if (alu_op != 8'h00) {alu_z, alu_n, alu_c, alu_v, alu_h, alu_out} <= alu_ref(alu_op, alu_a, alu_b);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++;
      if (dbg_data !== mregs[i]) begin
        errors++; $display("FAIL %s r%0d: got %h exp %h", tag, i, dbg_data, mregs[i]);
      end
    end
  endtask

  // Issues one instruction through the handshake and checks every phase.
  task automatic run_instr(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] ra,
                           input logic [2:0] rb, input logic imm_en, input logic [31:0] imm,
                           input string tag);
    logic [31:0] a, b;
    logic [36:0] r;
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin step(); n++; end
    checks++;
    if (!instr_ready) begin errors++; $display("FAIL %s ready timeout: got 0 exp 1", tag); end
    a = mregs[ra];
    b = imm_en ? imm : mregs[rb];
    r = alu_ref(op, a, b);
    instr_valid = 1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
    instr_imm_en = imm_en; instr_imm = imm;
    step();
    instr_valid = 0;
    // Scramble the fields: they must only be sampled on the accept edge.
    instr_op = 8'($urandom); instr_ra = 3'($urandom); instr_rb = 3'($urandom);
    instr_imm = $urandom; instr_imm_en = 1'($urandom);
    if (legal_op(op)) begin
      checks++;
      if (alu_op !== op) begin errors++; $display("FAIL %s issue alu_op: got %h exp %h", tag, alu_op, op); end
      checks++;
      if (alu_a !== a || alu_b !== b) begin
        errors++; $display("FAIL %s operands: got %h/%h exp %h/%h", tag, alu_a, alu_b, a, b);
      end
      checks++;
      if (done !== 0 || instr_ready !== 0) begin
        errors++; $display("FAIL %s issue done/ready: got %b%b exp 00", tag, done, instr_ready);
      end
      step();
      dbg_addr = rd; #1;
      checks++;
      if (done !== 1 || alu_op !== 8'h00) begin
        errors++; $display("FAIL %s wb done/alu_op: got %b/%h exp 1/00", tag, done, alu_op);
      end
      checks++;
      if (dbg_data !== mregs[rd]) begin
        errors++; $display("FAIL %s wb old rd: got %h exp %h", tag, dbg_data, mregs[rd]);
      end
      step();
      mregs[rd] = r[31:0];
      if (op != 8'h01) mregs[rd] = r[31:0];
      if (op != 8'h01) mstatus = r[36:32];
      checks++;
      if (dbg_data !== mregs[rd]) begin
        errors++; $display("FAIL %s result r%0d: got %h exp %h", tag, rd, dbg_data, mregs[rd]);
      end
      checks++;
      if (status !== mstatus || done !== 0 || instr_ready !== 1) begin
        errors++; $display("FAIL %s post status/done/ready: got %b/%b/%b exp %b/0/1",
                           tag, status, done, instr_ready, mstatus);
      end
    end else begin
      checks++;
      if (err !== 1 || alu_op !== 8'h00 || instr_ready !== 0 || done !== 0) begin
        errors++; $display("FAIL %s err phase: got err=%b op=%h rdy=%b done=%b exp 1/00/0/0",
                           tag, err, alu_op, instr_ready, done);
      end
      step();
      checks++;
      if (err !== 0 || instr_ready !== 1 || status !== mstatus) begin
        errors++; $display("FAIL %s after err: got err=%b rdy=%b st=%b exp 0/1/%b",
                           tag, err, instr_ready, status, mstatus);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; instr_valid = 0; instr_op = 0; instr_rd = 0; instr_ra = 0; instr_rb = 0;
    instr_imm_en = 0; instr_imm = 0; dbg_addr = 0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mstatus = '0;
    #13;
    checks++;
    if (instr_ready !== 1 || done !== 0 || err !== 0 || alu_op !== 8'h00 ||
        alu_a !== 0 || alu_b !== 0 || status !== 0) begin
      errors++; $display("FAIL reset outputs: got rdy=%b done=%b err=%b op=%h a=%h b=%h st=%b exp 1/0/0/00/0/0/0",
                         instr_ready, done, err, alu_op, alu_a, alu_b, status);
    end
    check_all_regs("reset");
    rst = 0;
    step();
  endtask

  task automatic test_add();
    run_instr(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, "ld_r1");
    run_instr(8'h01, 3'd2, 3'd0, 3'd0, 1'b1, 32'd7, "ld_r2");
    run_instr(8'h03, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, "add");
    dbg_addr = 3'd3; #1;
    checks++;
    if (dbg_data !== 32'd12 || status !== 5'b00000) begin
      errors++; $display("FAIL add_const: got r3=%h st=%b exp 0000000c/00000", dbg_data, status);
    end
  endtask

  task automatic test_sub_ld();
    run_instr(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 32'd9, "ld9_r1");
    run_instr(8'h01, 3'd2, 3'd0, 3'd0, 1'b1, 32'd9, "ld9_r2");
    run_instr(8'h04, 3'd4, 3'd1, 3'd2, 1'b0, 32'd0, "sub");
    run_instr(8'h01, 3'd5, 3'd0, 3'd4, 1'b0, 32'd0, "ld_r5");
    dbg_addr = 3'd5; #1;
    checks++;
    if (dbg_data !== 32'd0 || status[4] !== 1'b1) begin
      errors++; $display("FAIL sub_ld_const: got r5=%h Z=%b exp 0/1", dbg_data, status[4]);
    end
  endtask

  task automatic test_err();
    run_instr(8'h02, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, "illegal02");
    check_all_regs("after_err");
  endtask

  task automatic test_imm_boundary();
    run_instr(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 32'd1, "ld1");
    run_instr(8'h03, 3'd3, 3'd1, 3'd0, 1'b1, 32'hFFFF_FFFF, "add_imm");
    dbg_addr = 3'd3; #1;
    checks++;
    if (dbg_data !== 32'd0 || status[4] !== 1'b1 || status[2] !== 1'b1) begin
      errors++; $display("FAIL add_imm_const: got r3=%h st=%b exp 0/Z=1,C=1", dbg_data, status);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ops [3];
    logic [2:0]  rds [3];
    logic [2:0]  ras [3];
    logic [31:0] imms [3];
    int          acc [3];
    int          idx, cyc;
    logic        take;
    logic [36:0] r;
    ops  = '{8'h03, 8'h03, 8'h07};
    rds  = '{3'd1, 3'd1, 3'd7};
    ras  = '{3'd1, 3'd1, 3'd1};
    imms = '{32'd3, 32'd4, 32'h0000_00F0};
    idx = 0; cyc = 0;
    instr_valid = 1; instr_imm_en = 1; instr_rb = 0;
    instr_op = ops[0]; instr_rd = rds[0]; instr_ra = ras[0]; instr_imm = imms[0];
    while (idx < 3 && cyc < 40) begin
      take = instr_ready;
      r = alu_ref(ops[idx], mregs[ras[idx]], imms[idx]);
      step(); cyc++;
      if (take) begin
        acc[idx] = cyc;
        mregs[rds[idx]] = r[31:0];
        mstatus = r[36:32];
        idx++;
        if (idx < 3) begin
          instr_op = ops[idx]; instr_rd = rds[idx]; instr_ra = ras[idx]; instr_imm = imms[idx];
        end else instr_valid = 0;
      end
    end
    checks++;
    if (idx < 3) begin
      errors++; $display("FAIL b2b timeout: got %0d accepts exp 3", idx);
    end else begin
      checks++;
      if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
        errors++; $display("FAIL b2b spacing: got %0d,%0d exp 3,3", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    step(); step(); step();
    check_all_regs("b2b");
    checks++;
    if (status !== mstatus) begin errors++; $display("FAIL b2b status: got %b exp %b", status, mstatus); end
  endtask

  task automatic test_random();
    logic [7:0] tbl [14];
    tbl = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
            8'h01, 8'h02, 8'h00, 8'h0B, 8'hFF};
    for (int i = 0; i < 8; i++)
      run_instr(8'h01, 3'(i), 3'd0, 3'd0, 1'b1, $urandom, "rnd_ld");
    for (int i = 0; i < 40; i++)
      run_instr(tbl[$urandom_range(13)], 3'($urandom), 3'($urandom), 3'($urandom),
                1'($urandom), $urandom, $sformatf("rnd%0d", i));
    check_all_regs("rnd_final");
  endtask

  task automatic test_reset_mid_wb();
    int n;
    run_instr(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 32'd20, "pre_ld1");
    run_instr(8'h01, 3'd2, 3'd0, 3'd0, 1'b1, 32'd22, "pre_ld2");
    run_instr(8'h04, 3'd0, 3'd1, 3'd2, 1'b0, 32'd0, "pre_sub");
    n = 0;
    while (!instr_ready && n < 10) begin step(); n++; end
    instr_valid = 1; instr_op = 8'h03; instr_rd = 3'd6; instr_ra = 3'd1; instr_rb = 3'd2; instr_imm_en = 0;
    step();
    instr_valid = 0;
    step();
    checks++;
    if (done !== 1) begin errors++; $display("FAIL rstwb reach wb: got done=%b exp 1", done); end
    #2 rst = 1;
    #1;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mstatus = '0;
    dbg_addr = 3'd6; #1;
    checks++;
    if (dbg_data !== 0 || status !== 0 || done !== 0 || instr_ready !== 1 || alu_op !== 8'h00) begin
      errors++; $display("FAIL rstwb during reset: got r6=%h st=%b done=%b rdy=%b op=%h exp 0/0/0/1/00",
                         dbg_data, status, done, instr_ready, alu_op);
    end
    rst = 0;
    step();
    checks++;
    if (dbg_data !== 0 || status !== 0 || done !== 0 || instr_ready !== 1) begin
      errors++; $display("FAIL rstwb after release: got r6=%h st=%b done=%b rdy=%b exp 0/0/0/1",
                         dbg_data, status, done, instr_ready);
    end
    check_all_regs("rstwb");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_ld();
    test_err();
    test_imm_boundary();
    test_back_to_back();
    test_random();
    test_reset_mid_wb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, system clock; all state changes on rising edge.
REQ-002 The block SHALL have these ports: rst, input, 1, asynchronous active-high reset.
REQ-003 The block SHALL have these ports: instr_valid in 1, instr_ready out 1, instruction handshake.
REQ-004 The block SHALL have these ports: instr_op in 8, instr_rd in 3, instr_ra in 3, instr_rb in 3, instr_imm_en in 1, instr_imm in 32, instruction fields.
REQ-005 The block SHALL have these ports: alu_a out 32, alu_b out 32, alu_op out 8, operands and opcode to the ALU.
REQ-006 The block SHALL have these ports: alu_out in 32, and alu_z, alu_n, alu_c, alu_v, alu_h in 1 each, ALU result and flags.
REQ-007 The block SHALL have these ports: status out 5 {Z,N,C,V,H}, done out 1, err out 1.
REQ-008 The block SHALL have these ports: dbg_addr in 3 and dbg_data out 32, a combinational register-file read port.

Function
REQ-009 The block SHALL hold an 8x32 register file and a 5-bit status register.
REQ-010 The FSM SHALL have the states IDLE, ISSUE, WB and ERR.
REQ-011 instr_ready SHALL be 1 only in IDLE; an instruction is accepted on a rising edge with instr_valid and instr_ready both high.
REQ-012 Legal opcodes SHALL be 01 and 03 through 0A; on accept of a legal opcode the FSM SHALL go IDLE->ISSUE, otherwise IDLE->ERR.
REQ-013 On accept, alu_a SHALL be registered as reg[ra], and alu_b as instr_imm if instr_imm_en=1, else reg[rb]; alu_op SHALL be registered as instr_op.
REQ-014 alu_op SHALL be 8'h00 in every state except ISSUE, so the ALU holds its output.
REQ-015 ISSUE SHALL last one cycle; the ALU evaluates on the falling edge; the rising edge ending ISSUE SHALL capture alu_out and the five flags into internal registers and go to WB.
REQ-016 done SHALL be 1 for exactly the WB cycle; the rising edge ending WB SHALL write the captured result to reg[rd] and return the FSM to IDLE.
REQ-017 At the end of WB, status SHALL be updated from the captured flags, except for opcode 01 (LD), which leaves status unchanged.
REQ-018 Latency from accept edge to writeback edge SHALL be 2 cycles; throughput SHALL be 1 instruction per 3 cycles.
REQ-019 ERR SHALL last one cycle with err=1, with no ALU issue, no register write and no status change, then return to IDLE.
REQ-020 A read of rd in the same cycle it is written SHALL return the old value; there is no forwarding, because acceptance is blocked until IDLE.
REQ-021 Arithmetic is owned by the ALU; the block SHALL not alter result width or flags, and shift amounts are passed unchanged.
REQ-022 instr_valid SHALL be ignored outside IDLE, and fields SHALL be sampled only on the accept edge.

Reset
REQ-023 Assertion of rst SHALL immediately force IDLE, all registers and status to 0, alu_a=alu_b=0, alu_op=00, done=err=0, and instr_ready=1 once rst is released.
REQ-024 A reset during ISSUE or WB SHALL abort the instruction with no register write and no status update.

Structure
REQ-025 A shared package SHALL hold the opcode constants (LD=01, ADD=03, SUB=04, AND=05, OR=06, XOR=07, NOT=08, SL=09, SR=0A), the FSM state encoding and the status bit indices.
REQ-026 The register file SHALL be a sub-module, alu_regfile, with two combinational read ports, one debug read port and one synchronous write port with asynchronous clear.

Verification
REQ-027 With r1=5 and r2=7, ADD rd=3, ra=1, rb=2 -> alu_op=03 in ISSUE only, done pulses 2 cycles after accept, r3=12, status=00000.
REQ-028 SUB with r1=r2=9, rd=4 -> r4=0 and status Z=1; a following LD r5 from r4 -> r5=0 and status still Z=1.
REQ-029 instr_op=02 -> err=1 for one cycle, alu_op stays 00, all registers and status unchanged, instr_ready returns high the next cycle.
REQ-030 Back-to-back valid held high for 3 instructions -> accepts spaced exactly 3 cycles apart, results in order.
REQ-031 rst asserted mid-WB of ADD rd=6 -> r6=0, status=0, done=0, FSM in IDLE.
REQ-032 ADD with imm_en=1, imm=32'hFFFFFFFF, r1=1 -> result 0, Z=1, C=1.
